// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   Decode-to-execute pipeline register with a one-entry skid buffer.
//   Source operands are resolved once, when an instruction is captured:
//   either from EX/MEM and MEM/WB forwarding (MEM wins), or, in the default
//   build, by stalling decode while a register hazard is outstanding.
//
//   Configuration macro: ID_EX_FORWARD_EN
//     defined   -> forwarding muxes on rs1/rs2 at capture
//     undefined -> no forwarding; in_ready drops on a RAW hazard against a
//                  held entry or an in-flight fwd_mem / fwd_wb writer
//
//   Ports
//     clk, rst                        clock, async active-high reset
//     in_valid / in_ready             decode handshake
//     in_rs1_data, in_rs2_data        register-file read data
//     in_rs1_addr, in_rs2_addr        source register indices
//     in_imm, in_use_imm              immediate and B-select
//     in_ALUop, in_Unsigned           ALU control
//     in_rd, in_reg_write             destination and write-enable
//     fwd_mem_*, fwd_wb_*             EX/MEM and MEM/WB results
//     flush                           drop all held entries
//     out_valid / out_ready           ALU handshake
//     A, B, ALUop, Unsigned           ALU operands and control
//     out_rd, out_reg_write           destination and write-enable
// -----------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [4:0]  in_rs1_addr,
    input  logic [4:0]  in_rs2_addr,
    input  logic [31:0] in_imm,
    input  logic        in_use_imm,
    input  logic [2:0]  in_ALUop,
    input  logic        in_Unsigned,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic        fwd_mem_we,
    input  logic [4:0]  fwd_mem_rd,
    input  logic [31:0] fwd_mem_data,
    input  logic        fwd_wb_we,
    input  logic [4:0]  fwd_wb_rd,
    input  logic [31:0] fwd_wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  ALUop,
    output logic        Unsigned,
    output logic [4:0]  out_rd,
    output logic        out_reg_write
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        uns;
        logic [4:0]  rd;
        logic        we;
    } entry_t;

    entry_t      r_main;
    entry_t      r_skid;
    logic        r_main_valid;
    logic        r_skid_valid;

    entry_t      w_cap;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic        w_up;
    logic        w_down;

`ifdef ID_EX_FORWARD_EN
    // Register 0 is hard-wired, so it is never forwarded; MEM is younger
    // than WB and therefore takes priority.
    function automatic logic [31:0] f_resolve(
        input logic [4:0]  rs,
        input logic [31:0] rf_data,
        input logic        mem_we,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_data,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data
    );
        if (rs != 5'd0 && mem_we && mem_rd == rs)
            return mem_data;
        else if (rs != 5'd0 && wb_we && wb_rd == rs)
            return wb_data;
        else
            return rf_data;
    endfunction

    assign w_rs1_val = f_resolve(in_rs1_addr, in_rs1_data, fwd_mem_we, fwd_mem_rd,
                                 fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    assign w_rs2_val = f_resolve(in_rs2_addr, in_rs2_data, fwd_mem_we, fwd_mem_rd,
                                 fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);

    // Depends only on registered state, so out_ready never reaches in_ready.
    assign in_ready  = !r_skid_valid;
`else
    logic w_hazard;
    logic w_unused_fwd_data;

    // True when a writer of rd would change a source the new instruction
    // actually reads (rs2 is ignored when B comes from the immediate).
    function automatic logic f_targets(
        input logic [4:0] rd,
        input logic       we,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_imm
    );
        return we && (rd != 5'd0) && ((rd == rs1) || (!use_imm && (rd == rs2)));
    endfunction

    assign w_rs1_val = in_rs1_data;
    assign w_rs2_val = in_rs2_data;

    // A held entry stalls decode even if it is leaving this cycle; this keeps
    // out_ready off the in_ready path.
    assign w_hazard =
        (r_main_valid && f_targets(r_main.rd, r_main.we, in_rs1_addr, in_rs2_addr, in_use_imm)) ||
        (r_skid_valid && f_targets(r_skid.rd, r_skid.we, in_rs1_addr, in_rs2_addr, in_use_imm)) ||
        f_targets(fwd_mem_rd, fwd_mem_we, in_rs1_addr, in_rs2_addr, in_use_imm) ||
        f_targets(fwd_wb_rd,  fwd_wb_we,  in_rs1_addr, in_rs2_addr, in_use_imm);

    assign in_ready          = !r_skid_valid && !w_hazard;
    assign w_unused_fwd_data = ^{fwd_mem_data, fwd_wb_data};
`endif

    // NOTE: every field gets a value on every pass, so no latch is inferred.
    always_comb begin
        w_cap.a   = w_rs1_val;
        w_cap.b   = in_use_imm ? in_imm : w_rs2_val;
        w_cap.op  = in_ALUop;
        w_cap.uns = in_Unsigned;
        w_cap.rd  = in_rd;
        w_cap.we  = in_reg_write;
    end

    assign w_up   = in_valid && in_ready;
    assign w_down = r_main_valid && out_ready;

    // NOTE: payload registers are reset too, so the ALU outputs read zero
    // during reset; all state updates use non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_down) begin
            if (r_skid_valid) begin
                // Skid full means in_ready was low: no upstream transfer here.
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_up) begin
                r_main       <= w_cap;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_up) begin
            if (!r_main_valid) begin
                r_main       <= w_cap;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= w_cap;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid     = r_main_valid;
    assign A             = r_main.a;
    assign B             = r_main.b;
    assign ALUop         = r_main.op;
    assign Unsigned      = r_main.uns;
    assign out_rd        = r_main.rd;
    assign out_reg_write = r_main.we;

endmodule
